// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter for the single-port program/data RAM.
// Grants one Avalon-MM transfer per cycle, supports bounded lock and steers read returns.
module ram_arbiter #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BE_W     = 4,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              rr_last_r, rr_last_s;
  logic [CNT_W-1:0]  lock_cnt_r, lock_cnt_s;
  logic              clken_r;
  logic              rd_valid0_r, rd_valid1_r;
  logic [ADDR_W-1:0] last_addr_r;
  logic [BE_W-1:0]   last_be_r;
  logic [DATA_W-1:0] last_wdata_r;

  logic              req0_s, req1_s;
  logic              owner_active_s, owner_id_s;
  logic              grant_valid_s, grant_id_s;
  logic              sel_read_s, sel_write_s, sel_lock_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [BE_W-1:0]   sel_be_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Grant decision: a locked owner keeps the RAM, otherwise round-robin on ties.
  always_comb begin
    req0_s         = m0_read | m0_write;
    req1_s         = m1_read | m1_write;
    owner_active_s = 1'b0;
    owner_id_s     = 1'b0;
    grant_valid_s  = 1'b0;
    grant_id_s     = 1'b0;
    case (state_r)
      OWN0: begin
        owner_active_s = req0_s;
        owner_id_s     = 1'b0;
      end
      OWN1: begin
        owner_active_s = req1_s;
        owner_id_s     = 1'b1;
      end
      default: begin
        owner_active_s = 1'b0;
        owner_id_s     = 1'b0;
      end
    endcase
    if (!clken_r) begin
      grant_valid_s = 1'b0;
    end else if (owner_active_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = owner_id_s;
    end else if (req0_s && req1_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~rr_last_r;
    end else if (req0_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (req1_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
    end
  end

  // Command mux from the granted master.
  always_comb begin
    if (grant_id_s) begin
      sel_read_s  = m1_read;
      sel_write_s = m1_write;
      sel_lock_s  = m1_lock;
      sel_addr_s  = m1_address;
      sel_be_s    = m1_byteenable;
      sel_wdata_s = m1_writedata;
    end else begin
      sel_read_s  = m0_read;
      sel_write_s = m0_write;
      sel_lock_s  = m0_lock;
      sel_addr_s  = m0_address;
      sel_be_s    = m0_byteenable;
      sel_wdata_s = m0_writedata;
    end
  end

  // Next state, lock counter and round-robin pointer.
  always_comb begin
    state_s    = IDLE;
    lock_cnt_s = '0;
    rr_last_s  = rr_last_r;
    if (grant_valid_s) begin
      rr_last_s = grant_id_s;
      if (sel_lock_s) begin
        if (owner_active_s) begin
          // The transfer that brings the count to MAX_LOCK is the owner's last.
          if (lock_cnt_r >= LOCK_LAST) begin
            state_s    = IDLE;
            lock_cnt_s = '0;
          end else begin
            state_s    = state_r;
            lock_cnt_s = lock_cnt_r + CNT_W'(1);
          end
        end else if (MAX_LOCK > 1) begin
          state_s    = grant_id_s ? OWN1 : OWN0;
          lock_cnt_s = CNT_W'(1);
        end else begin
          state_s = IDLE;
        end
      end else begin
        state_s = IDLE;
      end
    end else begin
      state_s = IDLE;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      rr_last_r  <= 1'b1;
      lock_cnt_r <= '0;
      clken_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      rr_last_r  <= rr_last_s;
      lock_cnt_r <= lock_cnt_s;
      clken_r    <= 1'b1;
    end
  end

  // Read-return tags and last driven RAM command (held while idle).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid0_r  <= 1'b0;
      rd_valid1_r  <= 1'b0;
      last_addr_r  <= '0;
      last_be_r    <= '0;
      last_wdata_r <= '0;
    end else begin
      rd_valid0_r <= grant_valid_s & sel_read_s & ~sel_write_s & ~grant_id_s;
      rd_valid1_r <= grant_valid_s & sel_read_s & ~sel_write_s & grant_id_s;
      if (grant_valid_s) begin
        last_addr_r  <= sel_addr_s;
        last_be_r    <= sel_be_s;
        last_wdata_r <= sel_wdata_s;
      end else begin
        last_addr_r  <= last_addr_r;
        last_be_r    <= last_be_r;
        last_wdata_r <= last_wdata_r;
      end
    end
  end

  assign m0_waitrequest   = ~(grant_valid_s & ~grant_id_s);
  assign m1_waitrequest   = ~(grant_valid_s & grant_id_s);
  assign m0_readdatavalid = rd_valid0_r;
  assign m1_readdatavalid = rd_valid1_r;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign ram_chipselect   = grant_valid_s;
  assign ram_write        = grant_valid_s & sel_write_s;
  assign ram_address      = grant_valid_s ? sel_addr_s  : last_addr_r;
  assign ram_byteenable   = grant_valid_s ? sel_be_s    : last_be_r;
  assign ram_writedata    = grant_valid_s ? sel_wdata_s : last_wdata_r;
  assign ram_clken        = clken_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 2048x32 RAM behind it.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [10:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_readdata = 32'h0;
  logic [31:0] mem [0:2047];

  int n_cmp = 0;
  int n_fail = 0;
  logic prev_g;
  logic exp_g;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  // Synchronous RAM: one-cycle read latency, byte-lane writes.
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      ram_readdata <= mem[ram_address];
      if (ram_write) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic rd, input logic wr, input logic [10:0] a,
                      input logic [3:0] be, input logic [31:0] d, input logic lk);
    m0_read = rd; m0_write = wr; m0_address = a;
    m0_byteenable = be; m0_writedata = d; m0_lock = lk;
  endtask

  task automatic set1(input logic rd, input logic wr, input logic [10:0] a,
                      input logic [3:0] be, input logic [31:0] d, input logic lk);
    m1_read = rd; m1_write = wr; m1_address = a;
    m1_byteenable = be; m1_writedata = d; m1_lock = lk;
  endtask

  task automatic idle_all();
    set0(1'b0, 1'b0, 11'h0, 4'h0, 32'h0, 1'b0);
    set1(1'b0, 1'b0, 11'h0, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    // Reset state, with a request pending that must not be granted
    reset_n = 1'b0;
    idle_all();
    m0_read = 1'b1;
    #2;
    chk("rst_m0_wait", {31'h0, m0_waitrequest}, 32'h1);
    chk("rst_m1_wait", {31'h0, m1_waitrequest}, 32'h1);
    chk("rst_m0_rdv", {31'h0, m0_readdatavalid}, 32'h0);
    chk("rst_m1_rdv", {31'h0, m1_readdatavalid}, 32'h0);
    chk("rst_cs", {31'h0, ram_chipselect}, 32'h0);
    chk("rst_wr", {31'h0, ram_write}, 32'h0);
    chk("rst_clken", {31'h0, ram_clken}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_m0_wait", {31'h0, m0_waitrequest}, 32'h1);
    chk("rel_clken", {31'h0, ram_clken}, 32'h0);
    m0_read = 1'b0;

    // Single-master write then read-back
    @(negedge clk);
    chk("rel_clken1", {31'h0, ram_clken}, 32'h1);
    set0(1'b0, 1'b1, 11'h010, 4'hF, 32'hDEADBEEF, 1'b0);
    #1;
    chk("t1_wr_wait", {31'h0, m0_waitrequest}, 32'h0);
    chk("t1_wr_cs", {31'h0, ram_chipselect}, 32'h1);
    chk("t1_wr_we", {31'h0, ram_write}, 32'h1);
    chk("t1_wr_addr", {21'h0, ram_address}, 32'h010);
    chk("t1_wr_data", ram_writedata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_wr_rdv", {31'h0, m0_readdatavalid}, 32'h0);
    set0(1'b1, 1'b0, 11'h010, 4'hF, 32'h0, 1'b0);
    #1;
    chk("t1_rd_wait", {31'h0, m0_waitrequest}, 32'h0);
    chk("t1_rd_we", {31'h0, ram_write}, 32'h0);
    @(negedge clk);
    chk("t1_rdv0", {31'h0, m0_readdatavalid}, 32'h1);
    chk("t1_data", m0_readdata, 32'hDEADBEEF);
    chk("t1_rdv1", {31'h0, m1_readdatavalid}, 32'h0);
    idle_all();
    #1;
    chk("t1_idle_cs", {31'h0, ram_chipselect}, 32'h0);
    chk("t1_idle_we", {31'h0, ram_write}, 32'h0);
    chk("t1_idle_addr", {21'h0, ram_address}, 32'h010);
    chk("t1_idle_w0", {31'h0, m0_waitrequest}, 32'h1);
    chk("t1_idle_w1", {31'h0, m1_waitrequest}, 32'h1);

    // Preload the alternation words through m0
    @(negedge clk);
    set0(1'b0, 1'b1, 11'h000, 4'hF, 32'h0A0A0000, 1'b0);
    @(negedge clk);
    set0(1'b0, 1'b1, 11'h7FF, 4'hF, 32'h0B0B07FF, 1'b0);

    // m1 partial-byte write merges into an existing word
    @(negedge clk);
    idle_all();
    set1(1'b0, 1'b1, 11'h020, 4'hF, 32'h11223344, 1'b0);
    @(negedge clk);
    set1(1'b0, 1'b1, 11'h020, 4'h2, 32'h0000AB00, 1'b0);
    @(negedge clk);
    set1(1'b1, 1'b0, 11'h020, 4'hF, 32'h0, 1'b0);
    #1;
    chk("t3_rd_wait", {31'h0, m1_waitrequest}, 32'h0);
    @(negedge clk);
    chk("t3_rdv1", {31'h0, m1_readdatavalid}, 32'h1);
    chk("t3_data", m1_readdata, 32'h1122AB44);
    chk("t3_rdv0", {31'h0, m0_readdatavalid}, 32'h0);
    idle_all();

    // Both masters reading every cycle: strict alternation starting at m0
    prev_g = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        set0(1'b1, 1'b0, 11'h000, 4'hF, 32'h0, 1'b0);
        set1(1'b1, 1'b0, 11'h7FF, 4'hF, 32'h0, 1'b0);
      end else begin
        chk("t2_rdv0", {31'h0, m0_readdatavalid}, {31'h0, ~prev_g});
        chk("t2_rdv1", {31'h0, m1_readdatavalid}, {31'h0, prev_g});
        if (prev_g) chk("t2_data1", m1_readdata, 32'h0B0B07FF);
        else        chk("t2_data0", m0_readdata, 32'h0A0A0000);
      end
      #1;
      exp_g = (k % 2 == 1);
      chk("t2_w0", {31'h0, m0_waitrequest}, {31'h0, exp_g});
      chk("t2_w1", {31'h0, m1_waitrequest}, {31'h0, ~exp_g});
      prev_g = exp_g;
    end
    @(negedge clk);
    chk("t2_last_rdv1", {31'h0, m1_readdatavalid}, 32'h1);
    chk("t2_last_data", m1_readdata, 32'h0B0B07FF);
    idle_all();

    // m0 locks for 16 cycles while m1 waits, then lock drops and they alternate
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("t4_rdv0", {31'h0, m0_readdatavalid}, {31'h0, ~prev_g});
        chk("t4_rdv1", {31'h0, m1_readdatavalid}, {31'h0, prev_g});
      end
      set0(1'b1, 1'b0, 11'(i), 4'hF, 32'h0, (i < 17));
      set1(1'b1, 1'b0, 11'h7FF, 4'hF, 32'h0, 1'b0);
      #1;
      exp_g = (i < 16) ? 1'b0 : ((i - 16) % 2 == 0);
      chk("t4_w0", {31'h0, m0_waitrequest}, {31'h0, exp_g});
      chk("t4_w1", {31'h0, m1_waitrequest}, {31'h0, ~exp_g});
      prev_g = exp_g;
    end
    @(negedge clk);
    chk("t4_last_rdv0", {31'h0, m0_readdatavalid}, 32'h1);
    idle_all();

    // Read and write together: write wins, no read return
    @(negedge clk);
    set0(1'b1, 1'b1, 11'h030, 4'hF, 32'hCAFEF00D, 1'b0);
    #1;
    chk("t5_wait", {31'h0, m0_waitrequest}, 32'h0);
    chk("t5_we", {31'h0, ram_write}, 32'h1);
    @(negedge clk);
    chk("t5_no_rdv", {31'h0, m0_readdatavalid}, 32'h0);
    set0(1'b1, 1'b0, 11'h030, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    chk("t5_rdv", {31'h0, m0_readdatavalid}, 32'h1);
    chk("t5_data", m0_readdata, 32'hCAFEF00D);
    idle_all();

    // Reset with a read in flight drops the return
    @(negedge clk);
    set0(1'b1, 1'b0, 11'h010, 4'hF, 32'h0, 1'b0);
    #1;
    chk("t6_wait", {31'h0, m0_waitrequest}, 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rdv_rst", {31'h0, m0_readdatavalid}, 32'h0);
    @(negedge clk);
    chk("t6_w_rst", {31'h0, m0_waitrequest}, 32'h1);
    chk("t6_cs_rst", {31'h0, ram_chipselect}, 32'h0);
    chk("t6_clken_rst", {31'h0, ram_clken}, 32'h0);
    chk("t6_rdv_rst2", {31'h0, m0_readdatavalid}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t6_w_rel", {31'h0, m0_waitrequest}, 32'h1);
    @(negedge clk);
    chk("t6_clken", {31'h0, ram_clken}, 32'h1);
    chk("t6_rdv_rel", {31'h0, m0_readdatavalid}, 32'h0);
    #1;
    chk("t6_w_go", {31'h0, m0_waitrequest}, 32'h0);
    @(negedge clk);
    chk("t6_rdv_go", {31'h0, m0_readdatavalid}, 32'h1);
    chk("t6_data", m0_readdata, 32'hDEADBEEF);
    idle_all();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master round-robin arbiter that shares the single-port 2048×32 on-chip program/data RAM between the Nios II data master (m0) and a secondary Avalon-MM master (m1, e.g. DMA or display refresh). One transfer is issued to the RAM per clock cycle. Each grant carries a 1-cycle read-return tag so read data is steered back to the issuing master. A lock input lets a master hold the RAM for a bounded number of cycles for atomic read-modify-write sequences.

## Interface
- ADDR_W, 11, RAM word-address width (2048 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- MAX_LOCK, 16, maximum consecutive cycles a locked master may hold ownership (≥1)

- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- mX_address  in  ADDR_W  word address, X∈{0,1}
- mX_byteenable  in  BE_W  write byte lanes
- mX_read  in  1  read request
- mX_write  in  1  write request
- mX_writedata  in  DATA_W  write data
- mX_lock  in  1  request to keep ownership after current transfer
- mX_waitrequest  out  1  high = command not accepted this cycle
- mX_readdata  out  DATA_W  read data (valid only with readdatavalid)
- mX_readdatavalid  out  1  one-cycle read-return strobe
- ram_address  out  ADDR_W  to RAM address port
- ram_byteenable  out  BE_W  to RAM byteenable
- ram_writedata  out  DATA_W  to RAM write data
- ram_chipselect  out  1  RAM access strobe
- ram_write  out  1  RAM write enable (qualified by chipselect)
- ram_clken  out  1  RAM clock enable
- ram_readdata  in  DATA_W  RAM read data, valid one cycle after address

## Operation
- Request: mX_req = mX_read | mX_write. Both read and write high on one master: write is performed, read ignored, no readdatavalid.
- State machine (registered): IDLE, OWN0, OWN1. Reset → IDLE, rr_last=1 (m0 wins first tie).
- IDLE/unlocked arbitration, combinational per cycle: one requester → grant it; both → grant the master that is not rr_last. Grant updates rr_last.
- Granted master: waitrequest=0, its command driven to ram_*; ram_chipselect=1, ram_write=mX_write. Non-granted requester: waitrequest=1, command must be held stable (Avalon rule).
- No requester: ram_chipselect=0, ram_write=0, ram_address/byteenable/writedata hold last driven value; both waitrequest=1.
- Lock: if granted master has mX_lock=1 in its accept cycle, FSM → OWNX, lock_cnt loads 1. In OWNX only master X is granted; lock_cnt increments per cycle in OWNX. Exit to IDLE when mX_lock=0 at an accept, when X stops requesting, or when lock_cnt reaches MAX_LOCK (that cycle's transfer still completes; other master then wins the next tie).
- Read return: rd_tag_valid/rd_tag_id registered on an accepted read; next cycle mX_readdatavalid=1 for tag id, mX_readdata=ram_readdata (both masters' readdata buses may carry ram_readdata; only valid strobe is steered).
- ram_clken=1 constant after reset; no stall path.

## Timing
- Reset values: mX_waitrequest=1, mX_readdatavalid=0, ram_chipselect=0, ram_write=0, ram_clken=0 during reset, 1 from first clk after deassertion; FSM=IDLE, lock_cnt=0.
- Write: accepted and committed in cycle N (waitrequest low).
- Read: accepted cycle N, readdatavalid cycle N+1. Back-to-back reads every cycle supported, any master mix.
- Throughput: 1 transfer/cycle; with both masters continuously requesting and no lock, strict alternation m0,m1,m0,…
- Reset asserted with a read in flight: read return dropped, no readdatavalid after reset.
- Lock by one master while other requests: other waits at most MAX_LOCK cycles plus one.

## Test plan
- Reset then m0 write 0xDEADBEEF @0x010 be=0xF, then m0 read @0x010 -> waitrequest 0 both cycles, m0_readdatavalid next cycle with 0xDEADBEEF, m1 never strobed.
- m0 and m1 read continuously same cycle from 0x000/0x7FF -> grants alternate starting m0, each master readdatavalid every other cycle with correct data.
- m1 write be=0x2 data 0x0000AB00 to word preloaded 0x11223344 -> read returns 0x1122AB44.
- m0 lock held high, 40 back-to-back reads, m1 requesting -> m0 owns exactly 16 cycles, m1 granted on 17th, then alternation.
- m0 read and write both high -> write performed, no m0_readdatavalid.
- reset_n low in cycle after accepted read -> no readdatavalid, waitrequest=1, chipselect=0 until reset released.
